// File: rtl/dff_pipe.sv
// dff_pipe: DEPTH-stage, WIDTH-bit register pipeline with valid/ready handshake,
// per-stage bubble collapse, synchronous flush and a registered occupancy count.
module dff_pipe #(
  parameter int unsigned      WIDTH     = 8,
  parameter int unsigned      DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] r_v;
  logic [WIDTH-1:0] r_d [DEPTH];
  logic [OCC_W-1:0] r_occ;

  logic [DEPTH-1:0] w_ready;
  logic [DEPTH-1:0] w_up_v;
  logic [DEPTH-1:0] w_load;
  logic [WIDTH-1:0] w_up_d [DEPTH];
  logic             w_accept;
  logic             w_emit;
  logic [OCC_W-1:0] w_occ_nxt;

  // ready[i] = !v[i] | ready[i+1], unrolled from the output end with a scalar
  // carry so that no bit of w_ready is computed from another bit of itself.
  always_comb begin
    logic w_chain;
    w_chain = out_ready;
    w_ready = '0;
    for (int unsigned j = 0; j < DEPTH; j++) begin
      w_chain            = w_chain | ~r_v[DEPTH-1-j];
      w_ready[DEPTH-1-j] = w_chain;
    end
  end

  always_comb begin
    w_up_v    = '0;
    w_up_v[0] = in_valid;
    w_up_d[0] = in_data;
    for (int unsigned j = 1; j < DEPTH; j++) begin
      w_up_v[j] = r_v[j-1];
      w_up_d[j] = r_d[j-1];
    end
    w_load = w_up_v & w_ready & {DEPTH{~flush}};
  end

  assign in_ready = w_ready[0] & ~flush;
  assign w_accept = in_valid & in_ready;
  assign w_emit   = r_v[DEPTH-1] & out_ready;

  always_comb begin
    w_occ_nxt = r_occ;
    if (flush) begin
      w_occ_nxt = '0;
    end else if (w_accept && !w_emit) begin
      w_occ_nxt = r_occ + OCC_W'(1);
    end else if (!w_accept && w_emit) begin
      w_occ_nxt = r_occ - OCC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v   <= '0;
      r_occ <= '0;
      for (int unsigned j = 0; j < DEPTH; j++) begin
        r_d[j] <= RESET_VAL;
      end
    end else begin
      r_occ <= w_occ_nxt;
      for (int unsigned j = 0; j < DEPTH; j++) begin
        // A ready stage either takes the upstream word or empties as its own word leaves.
        if (flush) begin
          r_v[j] <= 1'b0;
        end else if (w_ready[j]) begin
          r_v[j] <= w_up_v[j];
        end
        if (w_load[j]) begin
          r_d[j] <= w_up_d[j];
        end
      end
    end
  end

  assign out_valid = r_v[DEPTH-1];
  assign out_data  = r_d[DEPTH-1];
  assign occupancy = r_occ;

endmodule

// File: tb/tb_dff_pipe.sv
// Bench for dff_pipe: directed phases with a queue scoreboard checked by a
// negedge monitor, plus a DEPTH=1/WIDTH=1 instance for the edge cases.
module tb_dff_pipe;

  localparam int W = 8;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] in_data, out_data;
  logic [2:0]   occupancy;

  logic         s_rst, s_flush, s_iv, s_ir, s_id, s_ov, s_or, s_od;
  logic [0:0]   s_occ;

  int           checks = 0;
  int           errors = 0;
  int           n_out  = 0;
  bit           mon_en = 1'b0;
  logic [W-1:0] sb[$];
  bit           prev_stall = 1'b0;
  logic [W-1:0] prev_data;

  dff_pipe #(.WIDTH(W), .DEPTH(D), .RESET_VAL(8'h5A)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy)
  );

  dff_pipe #(.WIDTH(1), .DEPTH(1), .RESET_VAL(1'b1)) dut1 (
    .clk(clk), .rst(s_rst), .flush(s_flush),
    .in_valid(s_iv), .in_ready(s_ir), .in_data(s_id),
    .out_valid(s_ov), .out_ready(s_or), .out_data(s_od),
    .occupancy(s_occ)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: model occupancy is the number of words in the scoreboard.
  always @(negedge clk) begin
    logic         exp_ir;
    logic [W-1:0] e;
    if (mon_en) begin
      exp_ir = !flush && ((sb.size() < D) || out_ready);
      chk("occupancy", 32'(occupancy), 32'(sb.size()));
      chk("in_ready", 32'(in_ready), 32'(exp_ir));
      if (prev_stall) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_data", 32'(out_data), 32'(prev_data));
      end
      if (rst) begin
        sb.delete();
      end else begin
        if (out_valid && out_ready) begin
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL out_extra: got word 0x%0h, required no word pending at %0t", out_data, $time);
          end else begin
            e = sb.pop_front();
            n_out++;
            chk("out_data", 32'(out_data), 32'(e));
          end
        end
        if (in_valid && exp_ir) sb.push_back(in_data);
        if (flush) sb.delete();
      end
      prev_stall = !rst && !flush && out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1);
  end

  initial begin
    int         acc;
    int         base;
    logic [3:0] pat;

    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 8'hFF; out_ready = 1'b1;
    s_rst = 1'b1; s_flush = 1'b0; s_iv = 1'b0; s_id = 1'b0; s_or = 1'b0;

    // Reset with a word offered throughout the reset window.
    tick();
    mon_en = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_occ", 32'(occupancy), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'h5A);
    tick();
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    base = n_out;
    for (int i = 0; i < 6; i++) begin
      tick();
      @(negedge clk);
      chk("rst_nothing_out", 32'(out_valid), 32'd0);
    end
    tick();
    chk("rst_no_words", 32'(n_out - base), 32'd0);

    // Full-rate stream 0x01..0x10: word k appears in cycle k+4.
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i > 0) tick();
      in_valid = (i < 16);
      in_data  = 8'(i + 1);
      @(negedge clk);
      if (i < 4) begin
        chk("stream_latency", 32'(out_valid), 32'd0);
      end else begin
        chk("stream_valid", 32'(out_valid), 32'd1);
        chk("stream_data", 32'(out_data), 32'(i - 3));
      end
      if (i >= 4 && i < 16) chk("stream_occ", 32'(occupancy), 32'd4);
    end
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("stream_drained", 32'(occupancy), 32'd0);

    // Back-pressure: only DEPTH words fit while the consumer stalls.
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 8'(acc + 1);
      @(negedge clk);
      if (in_ready) acc++;
    end
    chk("bp_accepted", 32'(acc), 32'd4);
    chk("bp_occ_full", 32'(occupancy), 32'd4);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_out_valid", 32'(out_valid), 32'd1);
    chk("bp_out_data", 32'(out_data), 32'h01);
    base = n_out;
    for (int i = 0; i < 20; i++) begin
      tick();
      out_ready = 1'b1;
      in_valid  = (acc < 6);
      in_data   = 8'(acc + 1);
      @(negedge clk);
      if (in_valid && in_ready) acc++;
    end
    tick();
    in_valid = 1'b0;
    chk("bp_all_accepted", 32'(acc), 32'd6);
    chk("bp_all_delivered", 32'(n_out - base), 32'd6);

    // Random handshakes with occasional flush; the monitor checks every cycle.
    for (int i = 0; i < 1200; i++) begin
      tick();
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 8'($urandom_range(0, 255));
      out_ready = (i < 600) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 2) == 0);
      flush     = ($urandom_range(0, 63) == 0);
    end
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (8) tick();
    @(negedge clk);
    chk("rand_drained", 32'(occupancy), 32'd0);
    chk("rand_out_valid", 32'(out_valid), 32'd0);

    // Flush with three words in flight and a word offered in the flush cycle.
    tick(); out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h11;
    tick(); in_data = 8'h22;
    tick(); in_data = 8'h33;
    tick(); in_valid = 1'b0;
    tick(); flush = 1'b1; in_valid = 1'b1; in_data = 8'hAA;
    @(negedge clk);
    chk("flush_in_ready", 32'(in_ready), 32'd0);
    chk("flush_occ_before", 32'(occupancy), 32'd3);
    chk("flush_head_valid", 32'(out_valid), 32'd1);
    chk("flush_head_data", 32'(out_data), 32'h11);
    tick(); flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush_occ_after", 32'(occupancy), 32'd0);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_data_kept", 32'(out_data), 32'h11);
    tick(); out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h55;
    @(negedge clk);
    for (int k = 1; k <= 4; k++) begin
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      if (k < 4) begin
        chk("flush_next_latency", 32'(out_valid), 32'd0);
      end else begin
        chk("flush_next_valid", 32'(out_valid), 32'd1);
        chk("flush_next_data", 32'(out_data), 32'h55);
      end
    end

    // DEPTH=1, WIDTH=1 instance.
    pat = 4'b0101;
    for (int k = 0; k < 4; k++) begin
      tick();
      s_rst = 1'b0; s_or = 1'b1; s_iv = 1'b1; s_id = pat[k];
      @(negedge clk);
      chk("d1_in_ready", 32'(s_ir), 32'd1);
      if (k == 0) begin
        chk("d1_rst_valid", 32'(s_ov), 32'd0);
        chk("d1_rst_data", 32'(s_od), 32'd1);
      end else begin
        chk("d1_rate_valid", 32'(s_ov), 32'd1);
        chk("d1_rate_data", 32'(s_od), 32'(pat[k-1]));
      end
    end
    tick(); s_rst = 1'b1; s_id = 1'b0;
    @(negedge clk);
    chk("d1_pre_rst_data", 32'(s_od), 32'd0);
    tick(); s_rst = 1'b0; s_iv = 1'b0;
    @(negedge clk);
    chk("d1_midrst_valid", 32'(s_ov), 32'd0);
    chk("d1_midrst_occ", 32'(s_occ), 32'd0);
    chk("d1_midrst_data", 32'(s_od), 32'd1);
    tick(); s_or = 1'b0; s_iv = 1'b1; s_id = 1'b0;
    @(negedge clk);
    chk("d1_load_ready", 32'(s_ir), 32'd1);
    tick(); s_iv = 1'b0;
    @(negedge clk);
    chk("d1_full_valid", 32'(s_ov), 32'd1);
    chk("d1_full_data", 32'(s_od), 32'd0);
    chk("d1_full_occ", 32'(s_occ), 32'd1);
    chk("d1_full_stall", 32'(s_ir), 32'd0);
    tick(); s_rst = 1'b1; s_flush = 1'b1; s_iv = 1'b1;
    tick(); s_rst = 1'b0; s_flush = 1'b0; s_iv = 1'b0;
    @(negedge clk);
    chk("d1_rstflush_valid", 32'(s_ov), 32'd0);
    chk("d1_rstflush_occ", 32'(s_occ), 32'd0);
    chk("d1_rstflush_data", 32'(s_od), 32'd1);
    chk("d1_rstflush_ready", 32'(s_ir), 32'd1);

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
